uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//    Lets NREQ requesters share one UartTX. A winner is picked, its word is
//    latched into TX_DATA, and the transmitter is loaded with a one-cycle
//    TX_LOAD strobe. The requester receives a matching one-cycle ACK. The
//    arbiter then waits for TX_BUSY to rise and fall before serving the next
//    request. If TX_BUSY never rises within BUSY_TIMEOUT cycles, the sticky
//    ERR flag is set and the arbiter returns to idle.
//
// Configuration:
//    UART_ARB_ROUND_ROBIN_EN
//       defined   : round-robin arbitration, searching upward from the last
//                   winner + 1 and wrapping around.
//       undefined : fixed priority, where the lowest index wins.
//
// Parameters:
//    NREQ         : number of requesters (2..8)
//    DW           : data word width per requester
//    BUSY_TIMEOUT : cycles allowed for TX_BUSY to rise after TX_LOAD (1..255)
//
// Ports:
//    CLK_100MHz : clock, all state changes on its rising edge
//    RST_N      : asynchronous active-low reset
//    REQ        : per-requester level request, held with DATA until ACK
//    DATA       : flattened words, requester i at [i*DW +: DW]
//    ACK        : one-cycle pulse to the requester whose word was loaded
//    GRANT      : one-hot current owner of the transmitter, zero when idle
//    TX_LOAD    : load strobe to UartTX
//    TX_DATA    : registered word to UartTX
//    TX_BUSY    : UartTX busy flag
//    ERR        : sticky timeout flag
//    CLR_ERR    : synchronous clear of ERR (a simultaneous timeout wins)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int DW           = 16,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic               CLK_100MHz,
   input  logic               RST_N,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*DW-1:0] DATA,
   output logic [NREQ-1:0]    ACK,
   output logic [NREQ-1:0]    GRANT,
   output logic               TX_LOAD,
   output logic [DW-1:0]      TX_DATA,
   input  logic               TX_BUSY,
   output logic               ERR,
   input  logic               CLR_ERR
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t          state;
   logic [7:0]      timeout_cnt;
   logic [7:0]      timeout_next;
   logic            req_found;
   logic [IW-1:0]   win_idx;
   logic [DW-1:0]   win_data;
   logic [NREQ-1:0] win_onehot;

`ifdef UART_ARB_ROUND_ROBIN_EN
   logic [IW-1:0]   rr_ptr;

   // Index reached by stepping k places above the pointer, with wrap-around.
   function automatic int wrap_idx(input int p, input int k);
      return (p + k) % NREQ;
   endfunction
`endif

   assign timeout_next = timeout_cnt + 8'd1;

   // Winner selection. The first requester found in search order wins, and
   // its word is picked out of the flattened DATA bus in the same pass.
   always_comb begin
      req_found  = 1'b0;
      win_idx    = '0;
      win_data   = '0;
      win_onehot = '0;
`ifdef UART_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NREQ; k++) begin
         if (!req_found && REQ[wrap_idx(int'(rr_ptr), k)]) begin
            req_found = 1'b1;
            win_idx   = IW'(wrap_idx(int'(rr_ptr), k));
            win_data  = DATA[wrap_idx(int'(rr_ptr), k)*DW +: DW];
         end
      end
`else
      // Scanning downward lets the lowest set index overwrite the others.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (REQ[k]) begin
            req_found = 1'b1;
            win_idx   = IW'(k);
            win_data  = DATA[k*DW +: DW];
         end
      end
`endif
      win_onehot[win_idx] = 1'b1;
   end

   // Main FSM. Every output is registered. TX_LOAD and ACK are set on the
   // transition into LOAD, so they are high only for the LOAD cycle. The
   // ERR set is written after the clear so that a same-cycle timeout wins.
   always_ff @(posedge CLK_100MHz or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         TX_LOAD     <= 1'b0;
         ACK         <= '0;
         GRANT       <= '0;
         TX_DATA     <= '0;
         ERR         <= 1'b0;
         timeout_cnt <= '0;
`ifdef UART_ARB_ROUND_ROBIN_EN
         rr_ptr      <= IW'(NREQ - 1);
`endif
      end else begin
         TX_LOAD <= 1'b0;
         ACK     <= '0;
         if (CLR_ERR) begin
            ERR <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!TX_BUSY && req_found) begin
                  TX_DATA <= win_data;
                  GRANT   <= win_onehot;
                  ACK     <= win_onehot;
                  TX_LOAD <= 1'b1;
                  state   <= LOAD;
`ifdef UART_ARB_ROUND_ROBIN_EN
                  rr_ptr  <= win_idx;
`endif
               end
            end
            LOAD: begin
               timeout_cnt <= '0;
               state       <= WAIT_START;
            end
            WAIT_START: begin
               if (TX_BUSY) begin
                  state <= WAIT_DONE;
               end else begin
                  timeout_cnt <= timeout_next;
                  if (timeout_next == 8'(BUSY_TIMEOUT)) begin
                     ERR   <= 1'b1;
                     GRANT <= '0;
                     state <= IDLE;
                  end
               end
            end
            WAIT_DONE: begin
               if (!TX_BUSY) begin
                  GRANT <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
